// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : menu_pkg
// Description : Shared types and key indices for the title-screen menu.
// Revision    : 1.0
// ============================================================================
package menu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FADE    = 2'd1,
        HANDOFF = 2'd2,
        DONE    = 2'd3
    } menu_state_t;

    // Colour order is {R, B, G}
    typedef logic [23:0] rgb_t;

    localparam int KEY_CONFIRM = 0;
    localparam int KEY_NEXT    = 1;
    localparam int KEY_PREV    = 2;

endpackage
`default_nettype wire

// File: rtl/menu_fade.sv
`default_nettype none
// ============================================================================
// Module      : menu_fade
// Description : Combinational colour scaler, channel * level / FADE_FRAMES.
// Revision    : 1.0
// ============================================================================
module menu_fade
    import menu_pkg::*;
#(
    parameter int FADE_FRAMES = 32
) (
    input  rgb_t                         i_color,
    input  logic [$clog2(FADE_FRAMES):0] i_level,
    output rgb_t                         o_color
);

    localparam int c_SHIFT = $clog2(FADE_FRAMES);
    localparam int c_PW    = 8 + c_SHIFT + 1;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [c_PW-1:0] w_prod;
        assign w_prod              = c_PW'(i_color[8*g +: 8]) * c_PW'(i_level);
        assign o_color[8*g +: 8]   = 8'(w_prod >> c_SHIFT);
    end

endmodule
`default_nettype wire

// File: rtl/menu_select.sv
`default_nettype none
// ============================================================================
// Module      : menu_select
// Description : Multi-item title menu: cursor, fade to black, start handoff.
// Revision    : 1.0
// ============================================================================
module menu_select
    import menu_pkg::*;
#(
    parameter int   N_ITEMS     = 3,
    parameter int   CORDW       = 16,
    parameter int   H_RES       = 800,
    parameter int   V_RES       = 600,
    parameter int   BOX_X0      = 280,
    parameter int   BOX_Y0      = 200,
    parameter int   BOX_W       = 240,
    parameter int   BOX_H       = 48,
    parameter int   BOX_GAP     = 16,
    parameter int   FADE_FRAMES = 32,
    parameter int   WRAP        = 1,
    parameter rgb_t BG_COLOR    = 24'h00FFFF,
    parameter rgb_t BOX_COLOR   = 24'h404040,
    parameter rgb_t SEL_COLOR   = 24'hFFC000
) (
    input  logic                         i_clk_pix,
    input  logic                         i_rst_n,
    input  logic                         i_frame,
    input  logic                         i_line,
    input  logic signed [CORDW-1:0]      i_sx,
    input  logic signed [CORDW-1:0]      i_sy,
    input  logic [2:0]                   i_key,
    input  logic                         i_main_ready,
    output logic                         o_main_start,
    output logic [$clog2(N_ITEMS)-1:0]   o_mode,
    output logic                         o_drawing,
    output logic                         o_processing,
    output logic [7:0]                   o_red,
    output logic [7:0]                   o_blue,
    output logic [7:0]                   o_green
);

    localparam int SELW = $clog2(N_ITEMS);
    localparam int FW   = $clog2(FADE_FRAMES) + 1;

    localparam logic [SELW-1:0] c_SEL_MAX   = SELW'(N_ITEMS - 1);
    localparam logic [FW-1:0]   c_FADE_FULL = FW'(FADE_FRAMES);
    localparam logic [FW-1:0]   c_FADE_LAST = FW'(FADE_FRAMES - 1);
    localparam int              c_X_END     = (BOX_X0 + BOX_W < H_RES) ? BOX_X0 + BOX_W : H_RES;
    localparam logic signed [CORDW-1:0] c_X0 = CORDW'(BOX_X0);
    localparam logic signed [CORDW-1:0] c_X1 = CORDW'(c_X_END);

    menu_state_t       r_state_q, w_state_d;
    logic [SELW-1:0]   r_sel_q,   w_sel_d;
    logic [FW-1:0]     r_fade_q,  w_fade_d;
    logic [2:0]        r_key_q;
    logic              r_start_q, w_start_d;
    logic              r_draw_q,  w_draw_d;
    rgb_t              r_rgb_q,   w_rgb_d;

    logic [2:0]         w_press;
    logic [N_ITEMS-1:0] w_hit;
    rgb_t               w_base;
    rgb_t               w_faded;
    logic [FW-1:0]      w_level;
    logic               w_unused;

    assign w_unused = i_line;
    assign w_press  = i_key & ~r_key_q;

    // Boxes are clipped to the active area; signed compares reject negative coordinates
    for (genvar k = 0; k < N_ITEMS; k++) begin : g_box
        localparam int c_Y_TOP = BOX_Y0 + k * (BOX_H + BOX_GAP);
        localparam int c_Y_END = (c_Y_TOP + BOX_H < V_RES) ? c_Y_TOP + BOX_H : V_RES;
        localparam logic signed [CORDW-1:0] c_Y0 = CORDW'(c_Y_TOP);
        localparam logic signed [CORDW-1:0] c_Y1 = CORDW'(c_Y_END);
        assign w_hit[k] = (i_sx >= c_X0) && (i_sx < c_X1) &&
                          (i_sy >= c_Y0) && (i_sy < c_Y1);
    end

    assign w_base  = w_hit[r_sel_q] ? SEL_COLOR : ((|w_hit) ? BOX_COLOR : BG_COLOR);
    assign w_level = c_FADE_FULL - r_fade_q;

    menu_fade #(
        .FADE_FRAMES (FADE_FRAMES)
    ) u_fade (
        .i_color (w_base),
        .i_level (w_level),
        .o_color (w_faded)
    );

    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= IDLE;
            r_sel_q   <= '0;
            r_fade_q  <= '0;
            r_key_q   <= '0;
            r_start_q <= 1'b0;
            r_draw_q  <= 1'b0;
            r_rgb_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_fade_q  <= w_fade_d;
            r_key_q   <= i_key;
            r_start_q <= w_start_d;
            r_draw_q  <= w_draw_d;
            r_rgb_q   <= w_rgb_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_fade_d  = r_fade_q;
        case (r_state_q)
            IDLE: begin
                if (w_press[KEY_CONFIRM]) begin
                    w_state_d = FADE;
                end else if (w_press[KEY_NEXT] && !w_press[KEY_PREV]) begin
                    if (r_sel_q != c_SEL_MAX) w_sel_d = r_sel_q + 1'b1;
                    else if (WRAP != 0)       w_sel_d = '0;
                end else if (w_press[KEY_PREV] && !w_press[KEY_NEXT]) begin
                    if (r_sel_q != '0)        w_sel_d = r_sel_q - 1'b1;
                    else if (WRAP != 0)       w_sel_d = c_SEL_MAX;
                end
            end
            FADE: begin
                if (i_frame) begin
                    w_fade_d = r_fade_q + 1'b1;
                    if (r_fade_q == c_FADE_LAST) w_state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (i_main_ready) w_state_d = DONE;
            end
            default: begin
                w_state_d = r_state_q;
            end
        endcase
    end

    always_comb begin
        o_processing = (r_state_q != DONE);
        w_start_d    = (w_state_d == HANDOFF);
        w_draw_d     = |w_hit;
        w_rgb_d      = w_faded;
        if (r_state_q == DONE) begin
            w_draw_d = 1'b0;
            w_rgb_d  = '0;
        end
    end

    assign o_main_start            = r_start_q;
    assign o_mode                  = r_sel_q;
    assign o_drawing               = r_draw_q;
    assign {o_red, o_blue, o_green} = r_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_select
// Description : Randomized bench for menu_select (wrapping and saturating).
// Revision    : 1.0
// ============================================================================
module tb_menu_select;

    localparam int   N    = 3;
    localparam int   FF   = 32;
    localparam logic [23:0] SEL_C = 24'hFFC000;
    localparam logic [23:0] BOX_C = 24'h404040;
    localparam logic [23:0] BG_C  = 24'h00FFFF;
    localparam int   P_IDLE = 0, P_FADE = 1, P_HAND = 2, P_DONE = 3;

    logic               r_clk = 1'b0;
    logic               r_rst_n = 1'b0;
    logic               r_frame = 1'b0;
    logic               r_line = 1'b0;
    logic               r_ready = 1'b0;
    logic signed [15:0] r_sx = '0;
    logic signed [15:0] r_sy = '0;
    logic [2:0]         r_key = '0;

    logic       w_start_a, w_draw_a, w_proc_a, w_start_b, w_draw_b, w_proc_b;
    logic [1:0] w_mode_a, w_mode_b;
    logic [7:0] w_r_a, w_b_a, w_g_a, w_r_b, w_b_b, w_g_b;

    int n_checks = 0;
    int n_errors = 0;

    int         m_sel_w, m_sel_s, m_phase, m_fcnt;
    logic [2:0] m_prev;
    int         e_start, e_draw_w, e_draw_s;
    logic [23:0] e_rgb_w, e_rgb_s;

    always #5 r_clk = ~r_clk;

    menu_select #(.WRAP(1)) u_dut_wrap (
        .i_clk_pix(r_clk), .i_rst_n(r_rst_n), .i_frame(r_frame), .i_line(r_line),
        .i_sx(r_sx), .i_sy(r_sy), .i_key(r_key), .i_main_ready(r_ready),
        .o_main_start(w_start_a), .o_mode(w_mode_a), .o_drawing(w_draw_a),
        .o_processing(w_proc_a), .o_red(w_r_a), .o_blue(w_b_a), .o_green(w_g_a)
    );

    menu_select #(.WRAP(0)) u_dut_sat (
        .i_clk_pix(r_clk), .i_rst_n(r_rst_n), .i_frame(r_frame), .i_line(r_line),
        .i_sx(r_sx), .i_sy(r_sy), .i_key(r_key), .i_main_ready(r_ready),
        .o_main_start(w_start_b), .o_mode(w_mode_b), .o_drawing(w_draw_b),
        .o_processing(w_proc_b), .o_red(w_r_b), .o_blue(w_b_b), .o_green(w_g_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference pixel: {drawing, colour} for a given cursor and fade progress
    function automatic logic [24:0] ref_pix(int sel, int phase, int fcnt, int x, int y);
        logic [23:0] base;
        logic [23:0] res;
        int hitk;
        int lvl;
        hitk = -1;
        for (int k = 0; k < N; k++)
            if (x >= 280 && x < 520 && y >= 200 + 64*k && y < 248 + 64*k) hitk = k;
        if (phase == P_DONE) return 25'd0;
        if (hitk < 0)         base = BG_C;
        else if (hitk == sel) base = SEL_C;
        else                  base = BOX_C;
        lvl = FF - fcnt;
        for (int c = 0; c < 3; c++) res[8*c +: 8] = 8'((int'(base[8*c +: 8]) * lvl) / FF);
        return {(hitk >= 0), res};
    endfunction

    task automatic reset_model();
        m_sel_w = 0; m_sel_s = 0; m_phase = P_IDLE; m_fcnt = 0; m_prev = '0;
        e_start = 0; e_draw_w = 0; e_draw_s = 0; e_rgb_w = '0; e_rgb_s = '0;
    endtask

    task automatic model_step();
        logic [2:0]  p;
        logic [24:0] pw, ps;
        p      = r_key & ~m_prev;
        m_prev = r_key;
        pw = ref_pix(m_sel_w, m_phase, m_fcnt, int'(r_sx), int'(r_sy));
        ps = ref_pix(m_sel_s, m_phase, m_fcnt, int'(r_sx), int'(r_sy));
        e_draw_w = int'(pw[24]); e_rgb_w = pw[23:0];
        e_draw_s = int'(ps[24]); e_rgb_s = ps[23:0];
        case (m_phase)
            P_IDLE: begin
                if (p[0]) m_phase = P_FADE;
                else if (p[1] && !p[2]) begin
                    m_sel_w = (m_sel_w + 1) % N;
                    m_sel_s = (m_sel_s < N-1) ? m_sel_s + 1 : m_sel_s;
                end else if (p[2] && !p[1]) begin
                    m_sel_w = (m_sel_w + N - 1) % N;
                    m_sel_s = (m_sel_s > 0) ? m_sel_s - 1 : 0;
                end
            end
            P_FADE: if (r_frame) begin
                m_fcnt++;
                if (m_fcnt == FF) m_phase = P_HAND;
            end
            P_HAND: if (r_ready) m_phase = P_DONE;
            default: m_phase = m_phase;
        endcase
        e_start = (m_phase == P_HAND) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("mode_wrap",  w_mode_a,  m_sel_w);
        chk("mode_sat",   w_mode_b,  m_sel_s);
        chk("start_wrap", w_start_a, e_start);
        chk("start_sat",  w_start_b, e_start);
        chk("proc_wrap",  w_proc_a,  (m_phase != P_DONE) ? 1 : 0);
        chk("proc_sat",   w_proc_b,  (m_phase != P_DONE) ? 1 : 0);
        chk("draw_wrap",  w_draw_a,  e_draw_w);
        chk("draw_sat",   w_draw_b,  e_draw_s);
        chk("rgb_wrap",   {w_r_a, w_b_a, w_g_a}, e_rgb_w);
        chk("rgb_sat",    {w_r_b, w_b_b, w_g_b}, e_rgb_s);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mode"},  {w_mode_a, w_mode_b}, 0);
        chk({tag, "_start"}, {w_start_a, w_start_b}, 0);
        chk({tag, "_draw"},  {w_draw_a, w_draw_b}, 0);
        chk({tag, "_rgb"},   {w_r_a, w_b_a, w_g_a} | {w_r_b, w_b_b, w_g_b}, 0);
        chk({tag, "_proc"},  {w_proc_a, w_proc_b}, 3);
    endtask

    task automatic step();
        @(posedge r_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        r_rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        reset_model();
        @(posedge r_clk);
        #1;
        check_reset("rst_hold");
        r_rst_n = 1'b1;
    endtask

    task automatic set_px(input int x, input int y);
        r_sx = 16'(x);
        r_sy = 16'(y);
    endtask

    task automatic rand_px();
        int bx[4] = '{279, 280, 519, 520};
        int by[8] = '{199, 200, 247, 248, 263, 264, 375, 376};
        case ($urandom % 5)
            0, 1: set_px(int'($urandom_range(270, 530)), int'($urandom_range(190, 400)));
            2:    set_px(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)));
            3:    set_px(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 700);
            default: set_px(bx[$urandom % 4], by[$urandom % 8]);
        endcase
    endtask

    function automatic logic rnd_bit(input int pct);
        return ($urandom % 100) < pct;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hold;
        int  guard;
        bit  aborted;
        reset_model();
        repeat (2) @(posedge r_clk);
        #1;
        check_reset("rst_init");
        r_rst_n = 1'b1;

        set_px(300, 210); step();
        set_px(300, 270); step();
        set_px(10, 10);   step();
        set_px(-10, 210); step();

        for (int ep = 0; ep < 6; ep++) begin
            if (ep > 0) async_reset();
            aborted = 1'b0;

            repeat (150) begin
                r_key   = {rnd_bit(35), rnd_bit(35), 1'b0};
                r_frame = rnd_bit(30);
                r_ready = rnd_bit(30);
                rand_px();
                step();
            end
            if (ep == 0) begin
                r_key = '0; step();
                r_key = 3'b010;
                repeat (100) begin rand_px(); step(); end
                r_key = 3'b110; step();
            end

            r_key = '0; step();
            r_key = 3'b001 | 3'((ep % 4) << 1);
            step();
            chk("confirm_proc", w_proc_a, 1);

            guard = 0;
            while (m_phase == P_FADE && guard < 3000) begin
                r_key   = 3'($urandom);
                r_frame = rnd_bit(33);
                r_ready = rnd_bit(50);
                rand_px();
                if (ep == 2 && m_fcnt == 10) begin
                    async_reset();
                    aborted = 1'b1;
                    break;
                end
                step();
                guard++;
            end
            if (aborted) continue;
            chk("fade_to_start", w_start_a, 1);

            hold    = (ep == 0) ? 50 : (ep == 1) ? 0 : int'($urandom_range(0, 5));
            r_ready = 1'b0;
            repeat (hold) begin
                r_key   = 3'($urandom);
                r_frame = rnd_bit(50);
                rand_px();
                step();
            end
            r_ready = 1'b1;
            step();
            chk("done_start", w_start_a, 0);
            chk("done_proc",  w_proc_a, 0);

            repeat (20) begin
                r_key   = 3'($urandom);
                r_frame = rnd_bit(50);
                r_ready = rnd_bit(50);
                rand_px();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
